keccak_multirate_padder: RTL

Parametrised successor to the fixed-rate SHA3-512 input padder. Accepts a big-endian byte stream of `IN_W`-bit words. Builds one rate-sized block at a time for SHA3-224, SHA3-256, SHA3-384 or SHA3-512, selected at run time. Applies Keccak (0x01) or SHA-3 (0x06) multi-rate padding and hands each completed block to the permutation core through a ready/ack handshake.

---
 rtl/keccak_multirate_padder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/keccak_multirate_padder.sv
// Multi-rate Keccak/SHA-3 input padder: packs IN_W-bit words into a left-aligned
// rate block for one of four rates, pads the final word and hands blocks off via ready/ack.
module keccak_multirate_padder #(
  parameter int IN_W       = 32,
  parameter int KECCAK_PAD = 1,
  localparam int BN_W      = $clog2(IN_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   in,
  input  logic              in_ready,
  input  logic              is_last,
  input  logic [BN_W-1:0]   byte_num,
  input  logic [1:0]        mode,
  input  logic              f_ack,
  output logic              buffer_full,
  output logic [1151:0]     out,
  output logic              out_ready,
  output logic              last_block
);

  localparam int OUT_W = 1152;
  localparam int WB    = IN_W / 8;
  localparam logic [7:0] PAD_BYTE = (KECCAK_PAD != 0) ? 8'h01 : 8'h06;

  typedef enum logic [1:0] {FILL, FULL, DONE} state_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             full_q, full_d;
  logic             rdy_q, rdy_d;
  logic             last_q, last_d;
  logic             started_q, started_d;
  logic [1:0]       mode_q, mode_d;

  logic [1:0]       mode_eff;
  logic [5:0]       blk_words;
  int               rate_lsb;
  logic [IN_W-1:0]  word;

  // The mode input is only honoured for the very first word of a message.
  always_comb begin
    mode_eff = started_q ? mode_q : mode;
    case (mode_eff)
      2'd0:    begin rate_lsb = 0;   blk_words = 6'(1152 / IN_W); end
      2'd1:    begin rate_lsb = 64;  blk_words = 6'(1088 / IN_W); end
      2'd2:    begin rate_lsb = 320; blk_words = 6'(832 / IN_W);  end
      default: begin rate_lsb = 576; blk_words = 6'(576 / IN_W);  end
    endcase
  end

  always_comb begin
    word = in;
    if (is_last) begin
      for (int b = 0; b < WB; b++) begin
        if (b == int'(byte_num))
          word[IN_W-1-8*b -: 8] = PAD_BYTE;
        else if (b > int'(byte_num))
          word[IN_W-1-8*b -: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    full_d    = full_q;
    rdy_d     = rdy_q;
    last_d    = last_q;
    started_d = started_q;
    mode_d    = mode_q;
    case (state_q)
      FILL: begin
        if (in_ready) begin
          started_d = 1'b1;
          mode_d    = mode_eff;
          out_d[OUT_W-1 - int'(cnt_q)*IN_W -: IN_W] = word;
          // Words after the final one are already zero since out is cleared per block.
          if (is_last) begin
            out_d[rate_lsb +: 8] = out_d[rate_lsb +: 8] | 8'h80;
            last_d  = 1'b1;
            full_d  = 1'b1;
            rdy_d   = 1'b1;
            state_d = FULL;
          end else if (cnt_q == blk_words - 6'd1) begin
            full_d  = 1'b1;
            rdy_d   = 1'b1;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      FULL: begin
        if (f_ack) begin
          rdy_d = 1'b0;
          if (last_q) begin
            state_d = DONE;
          end else begin
            full_d  = 1'b0;
            out_d   = '0;
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      out_q     <= '0;
      full_q    <= 1'b0;
      rdy_q     <= 1'b0;
      last_q    <= 1'b0;
      started_q <= 1'b0;
      mode_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      full_q    <= full_d;
      rdy_q     <= rdy_d;
      last_q    <= last_d;
      started_q <= started_d;
      mode_q    <= mode_d;
    end
  end

  assign buffer_full = full_q;
  assign out         = out_q;
  assign out_ready   = rdy_q;
  assign last_block  = last_q;

endmodule
